word_scan: RTL and testbench

- Tokenizer stage directly upstream of the number converter and dictionary search.
- Scans the 8-bit input buffer in synchronous memory from a start address, skipping leading delimiters.
- Reports the next token's start address, its length, and the resume address for the next scan.
- Downstream stages (atoi, find) begin fetching at tok_a once done pulses.

---
 rtl/word_scan_pkg.sv | 17 +
 rtl/word_scan.sv | 139 +++++++++++++
 tb/tb_word_scan.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/word_scan_pkg.sv
// Shared types for the word tokenizer stage.
// Scan states and character constants.
package word_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SKW,
    S_SKP,
    S_TKW,
    S_TOK,
    S_DONE
  } scan_st_t;

  localparam logic [7:0] SPC = 8'h20;
  localparam logic [7:0] NUL = 8'h00;

endpackage

// File: rtl/word_scan.sv
// Tokenizer: skips leading delimiters in memory and reports
// the next token's address, length and the resume address.
module word_scan
  import word_scan_pkg::*;
#(
  parameter int ASZ = 16,
  parameter int LSZ = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [ASZ-1:0] a0,
  input  logic [ASZ-1:0] a_end,
  input  logic [7:0]     delim,
  input  logic [7:0]     md,
  output logic [ASZ-1:0] ma,
  output logic           mre,
  output logic           bsy,
  output logic           done,
  output logic [ASZ-1:0] tok_a,
  output logic [LSZ-1:0] tok_len,
  output logic [ASZ-1:0] nxt_a,
  output logic           eol,
  output logic           ovf
);

  localparam logic [LSZ-1:0] LMAX = '1;
  localparam logic [ASZ-1:0] AONE = ASZ'(1);

  scan_st_t       st;
  logic [ASZ-1:0] a;
  logic [7:0]     dl;
  logic [LSZ-1:0] len;
  logic           term;
  logic           dlm;

  // With a space delimiter, every control char counts as whitespace.
  function automatic logic is_delim(
    input logic [7:0] ch,
    input logic [7:0] d
  );
    return (ch != NUL) &&
           ((ch == d) || ((d == SPC) && (ch <= SPC)));
  endfunction

  // End of buffer wins over whatever md holds.
  assign term = (a == a_end) || (md == NUL);
  assign dlm  = !term && is_delim(md, dl);
  assign ma   = a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_IDLE;
      a       <= '0;
      dl      <= '0;
      len     <= '0;
      mre     <= 1'b0;
      bsy     <= 1'b0;
      done    <= 1'b0;
      tok_a   <= '0;
      tok_len <= '0;
      nxt_a   <= '0;
      eol     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      mre  <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (start) begin
            a   <= a0;
            dl  <= delim;
            len <= '0;
            eol <= 1'b0;
            ovf <= 1'b0;
            bsy <= 1'b1;
            mre <= 1'b1;
            st  <= S_SKW;
          end
        end
        S_SKW: st <= S_SKP;
        S_SKP: begin
          unique case (1'b1)
            term: begin
              eol     <= 1'b1;
              tok_a   <= a;
              tok_len <= '0;
              nxt_a   <= a;
              bsy     <= 1'b0;
              done    <= 1'b1;
              st      <= S_DONE;
            end
            dlm: begin
              a   <= a + AONE;
              mre <= 1'b1;
              st  <= S_SKW;
            end
            default: begin
              tok_a <= a;
              len   <= LSZ'(1);
              a     <= a + AONE;
              mre   <= 1'b1;
              st    <= S_TKW;
            end
          endcase
        end
        S_TKW: st <= S_TOK;
        S_TOK: begin
          unique case (1'b1)
            term: begin
              tok_len <= len;
              nxt_a   <= a;
              bsy     <= 1'b0;
              done    <= 1'b1;
              st      <= S_DONE;
            end
            dlm: begin
              tok_len <= len;
              nxt_a   <= a + AONE;
              bsy     <= 1'b0;
              done    <= 1'b1;
              st      <= S_DONE;
            end
            default: begin
              a <= a + AONE;
              if (len == LMAX) ovf <= 1'b1;
              else len <= len + LSZ'(1);
              mre <= 1'b1;
              st  <= S_TKW;
            end
          endcase
        end
        S_DONE: st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_scan.sv
// Bench for word_scan: reference tokenizer model plus
// hand-computed expectations on directed buffers.
module tb_word_scan;

  localparam int ASZ = 16;
  localparam int LSZ = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [ASZ-1:0] a0 = '0;
  logic [ASZ-1:0] a_end = '0;
  logic [7:0]     delim = '0;
  logic [7:0]     md = '0;
  logic [ASZ-1:0] ma;
  logic           mre;
  logic           bsy;
  logic           done;
  logic [ASZ-1:0] tok_a;
  logic [LSZ-1:0] tok_len;
  logic [ASZ-1:0] nxt_a;
  logic           eol;
  logic           ovf;

  always #5 clk = ~clk;

  word_scan #(.ASZ(ASZ), .LSZ(LSZ)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a0(a0), .a_end(a_end), .delim(delim), .md(md),
    .ma(ma), .mre(mre), .bsy(bsy), .done(done),
    .tok_a(tok_a), .tok_len(tok_len), .nxt_a(nxt_a),
    .eol(eol), .ovf(ovf)
  );

  logic [7:0] mem [0:65535];

  always @(posedge clk) if (mre) md <= mem[ma];

  int n_cmp = 0;
  int n_bad = 0;

  int        e_lat, e_len, e_n;
  logic [15:0] e_tok_a, e_nxt;
  bit        e_eol, e_ovf;
  logic [15:0] e_addr [0:127];

  int        g_lat, g_len;
  logic [15:0] g_tok_a, g_nxt;
  bit        g_eol, g_ovf;

  bit chk_on = 0;
  int cyc = 0;

  task automatic cmp(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic bit isd(input logic [7:0] c, input logic [7:0] d);
    return (c != 8'h00) && ((c == d) || ((d == 8'h20) && (c <= 8'h20)));
  endfunction

  // Reference: walk the buffer as plain text, count evaluated chars.
  task automatic model(input logic [15:0] s, input logic [15:0] e,
                       input logic [7:0] d);
    logic [15:0] a;
    int cnt;
    bit skipping, inword;
    a = s; cnt = 0; e_n = 0;
    e_eol = 0; e_ovf = 0; e_tok_a = 0; e_nxt = 0;
    skipping = 1;
    while (skipping) begin
      e_addr[e_n] = a; e_n++;
      if (a == e || mem[a] == 8'h00) begin
        e_eol = 1; e_tok_a = a; e_nxt = a; skipping = 0;
      end else if (isd(mem[a], d)) begin
        a = a + 16'd1;
      end else begin
        e_tok_a = a; cnt = 1; a = a + 16'd1; skipping = 0;
      end
    end
    inword = !e_eol;
    while (inword) begin
      e_addr[e_n] = a; e_n++;
      if (a == e || mem[a] == 8'h00) begin
        e_nxt = a; inword = 0;
      end else if (isd(mem[a], d)) begin
        e_nxt = a + 16'd1; inword = 0;
      end else begin
        cnt++; a = a + 16'd1;
      end
    end
    e_len = (cnt > 31) ? 31 : cnt;
    e_ovf = (cnt > 31);
    e_lat = 2 * e_n + 1;
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      cyc++;
      cmp("bsy", 32'(bsy), 32'(cyc < e_lat));
      cmp("done", 32'(done), 32'(cyc == e_lat));
      cmp("mre", 32'(mre), 32'((cyc < e_lat) && (cyc % 2 == 1)));
      if ((cyc < e_lat) && (cyc % 2 == 1))
        cmp("ma", 32'(ma), 32'(e_addr[(cyc - 1) / 2]));
      if (done && g_lat == 0) begin
        g_lat = cyc; g_tok_a = tok_a; g_len = int'(tok_len);
        g_nxt = nxt_a; g_eol = eol; g_ovf = ovf;
      end
      if (cyc == e_lat) begin
        cmp("tok_a", 32'(tok_a), 32'(e_tok_a));
        cmp("tok_len", 32'(tok_len), 32'(e_len));
        cmp("nxt_a", 32'(nxt_a), 32'(e_nxt));
        cmp("eol", 32'(eol), 32'(e_eol));
        cmp("ovf", 32'(ovf), 32'(e_ovf));
        chk_on = 0;
      end
    end
  end

  task automatic launch(input logic [15:0] s, input logic [15:0] e,
                        input logic [7:0] d, input bit early);
    model(s, e, d);
    g_lat = 0;
    if (!early) begin @(posedge clk); #2; end
    start = 1'b1; a0 = s; a_end = e; delim = d;
    @(posedge clk);
    if (early) @(posedge clk);
    #2;
    cyc = 0; chk_on = 1;
  endtask

  task automatic finish_wait();
    int t;
    t = 0;
    while (chk_on && t < 200) begin
      @(negedge clk); #1; t++;
    end
    if (chk_on) begin
      chk_on = 0; n_cmp++; n_bad++;
      $display("FAIL timeout: no done within %0d cycles", t);
    end
  endtask

  task automatic scan(input logic [15:0] s, input logic [15:0] e,
                      input logic [7:0] d, input bit early, input bit spam);
    launch(s, e, d, early);
    if (spam) begin
      a0 = 16'h5555;
      repeat (e_lat - 1) @(posedge clk);
      #2;
    end
    start = 1'b0;
    finish_wait();
  endtask

  task automatic clr();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  endtask

  task automatic load(input logic [15:0] base, input string s);
    for (int i = 0; i < s.len(); i++) mem[base + 16'(i)] = s[i];
  endtask

  task automatic outs_zero(input string nm);
    cmp({nm, "_ma"}, 32'(ma), 0);
    cmp({nm, "_mre"}, 32'(mre), 0);
    cmp({nm, "_bsy"}, 32'(bsy), 0);
    cmp({nm, "_done"}, 32'(done), 0);
    cmp({nm, "_tok_a"}, 32'(tok_a), 0);
    cmp({nm, "_tok_len"}, 32'(tok_len), 0);
    cmp({nm, "_nxt_a"}, 32'(nxt_a), 0);
    cmp({nm, "_eol"}, 32'(eol), 0);
    cmp({nm, "_ovf"}, 32'(ovf), 0);
  endtask

  initial begin
    clr();
    repeat (2) @(negedge clk);
    outs_zero("rst");
    rst_n = 1'b1;

    // leading blanks, token "AB", one trailing blank consumed
    load(16'h0, "  AB ");
    scan(16'h0, 16'h8, 8'h20, 0, 0);
    cmp("t1_lat", 32'(g_lat), 11);
    cmp("t1_tok_a", 32'(g_tok_a), 2);
    cmp("t1_len", 32'(g_len), 2);
    cmp("t1_nxt", 32'(g_nxt), 5);
    cmp("t1_eol", 32'(g_eol), 0);

    // only control whitespace up to a_end
    clr();
    mem[0] = 8'h09; mem[1] = 8'h0D; mem[2] = 8'h0A;
    scan(16'h0, 16'h3, 8'h20, 0, 0);
    cmp("t2_lat", 32'(g_lat), 9);
    cmp("t2_eol", 32'(g_eol), 1);
    cmp("t2_len", 32'(g_len), 0);
    cmp("t2_nxt", 32'(g_nxt), 3);

    // comma-separated fields, then resume
    clr();
    load(16'h0, "-12,7");
    scan(16'h0, 16'h5, 8'h2C, 0, 0);
    cmp("t3_tok_a", 32'(g_tok_a), 0);
    cmp("t3_len", 32'(g_len), 3);
    cmp("t3_nxt", 32'(g_nxt), 4);
    scan(16'h4, 16'h5, 8'h2C, 0, 0);
    cmp("t3b_tok_a", 32'(g_tok_a), 4);
    cmp("t3b_len", 32'(g_len), 1);
    cmp("t3b_nxt", 32'(g_nxt), 5);
    cmp("t3b_eol", 32'(g_eol), 0);
    cmp("t3b_lat", 32'(g_lat), 5);

    // overlong token saturates
    clr();
    for (int i = 0; i < 40; i++) mem[i] = 8'h78;
    scan(16'h0, 16'h100, 8'h20, 0, 0);
    cmp("t4_len", 32'(g_len), 31);
    cmp("t4_ovf", 32'(g_ovf), 1);
    cmp("t4_nxt", 32'(g_nxt), 40);

    // reset in the middle of a token
    clr();
    load(16'h0, "HELLO");
    launch(16'h0, 16'h5, 8'h20, 0);
    start = 1'b0;
    while (cyc < 4) begin @(negedge clk); #1; end
    chk_on = 0;
    rst_n = 1'b0;
    #1;
    outs_zero("amid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("amid_nodone", 32'(done), 0);
    end
    rst_n = 1'b1;
    scan(16'h0, 16'h5, 8'h20, 0, 0);
    cmp("t5_len", 32'(g_len), 5);
    cmp("t5_ovf", 32'(g_ovf), 0);

    // start held through a scan, then start in the DONE cycle
    clr();
    load(16'h0, "  AB ");
    scan(16'h0, 16'h8, 8'h20, 0, 1);
    cmp("t6_tok_a", 32'(g_tok_a), 2);
    cmp("t6_len", 32'(g_len), 2);
    scan(16'hFFFF, 16'hFFFF, 8'h20, 1, 0);
    cmp("t6b_lat", 32'(g_lat), 3);
    cmp("t6b_eol", 32'(g_eol), 1);
    cmp("t6b_nxt", 32'(g_nxt), 16'hFFFF);

    // token wrapping past the top address
    clr();
    load(16'hFFFE, "QR");
    load(16'h0, "S ");
    scan(16'hFFFE, 16'h10, 8'h20, 0, 0);
    cmp("t7_tok_a", 32'(g_tok_a), 16'hFFFE);
    cmp("t7_len", 32'(g_len), 3);
    cmp("t7_nxt", 32'(g_nxt), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
